seg_scan: RTL and testbench
===========================

# seg_scan

Four-digit seven-segment display driver that sits directly downstream of the clock divider. It consumes the divider's display-refresh square wave and a one-cycle blink tick, converts a 14-bit binary value to BCD with a sequential double-dabble, and time-multiplexes the digits onto active-low anode and segment lines. Leading zeros are blanked, and the whole display can be blinked.

## Interface
- `DIGITS`, 4: number of multiplexed digits; fixed at 4, with no other value supported.
- `MAX_VAL`, 9999: saturation ceiling applied to `value`.
- `clk`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  reset; one clock, and reset is synchronous and active-low.
- `scan_clk`  in  1  display-refresh square wave from the divider, about 95 Hz, synchronous to `clk`. Each rising edge advances the digit.
- `blink_tick`  in  1  one-`clk` pulse from the divider; each pulse toggles the blink phase.
- `blink_en`  in  1  enables blinking.
- `value`  in  14  binary value to display; values above `MAX_VAL` saturate to 9999.
- `load`  in  1  request to capture `value`; accepted only when `busy`=0.
- `busy`  out  1  conversion in progress; `load` is ignored while high.
- `an`  out  4  active-low anodes; `an[0]` is the rightmost digit (ones).
- `seg`  out  7  active-low segments, ordered `{g,f,e,d,c,b,a}`.

## Operation
- **Converter FSM** has three states: IDLE, SHIFT, DONE.
  - IDLE to SHIFT on `load`. This captures `min(value, 9999)` and clears the 16-bit BCD scratch.
  - In SHIFT, each cycle adds 3 to every BCD nibble ≥5, then shifts left by one with the next binary MSB shifting in. SHIFT lasts exactly 14 cycles, counted by a 4-bit counter.
  - DONE writes the scratch into the 16-bit display register, then returns to IDLE.
- `busy` = (state ≠ IDLE).
- **Scan.** `scan_prev` registers `scan_clk`. A rising edge (`scan_clk & ~scan_prev`) increments the 2-bit digit index, which wraps 3→0.
- **Digit drive.** For index i, `seg` = pattern(BCD digit i) and `an` = one-hot-low on bit i, unless the digit is blanked.
- **Leading-zero blanking.** Digit i (i = 3..1) is blanked when it and all more-significant digits are zero. Digit 0 is never blanked, so a value of 0 shows "0".
- **Blinking.**
  - `blink_phase` toggles on `blink_tick` while `blink_en` = 1. It is forced to 0 whenever `blink_en` = 0.
  - When `blink_en` & `blink_phase`, `an` = 4'b1111.
- **Blank or off digit:** `an` = 4'b1111 and `seg` = 7'b1111111.
- **Reset values:**
  - Outputs: `an` = 4'b1111, `seg` = 7'b1111111, `busy` = 0.
  - Internal state: state = IDLE, digit index = 0, display register = 16'h0000, `blink_phase` = 0.
  - `scan_prev` resets to 1, so a `scan_clk` already high at reset release is not counted as an edge.

## Timing
- **Load accept:** `load` & ~`busy` sampled at edge N.
  - `busy` = 1 from cycle N+1 through N+15 (14 SHIFT cycles plus 1 DONE cycle).
  - The display register holds the new value from N+16, and `busy` = 0 at N+16.
- A new `load` can be accepted at N+16.
- **Scan latency:** a `scan_clk` rising edge sampled at edge M gives the new index at M+1. `an`/`seg` are registered and show the new digit at M+2.
- **Scan during DONE:** a scan edge coinciding with the DONE write uses the old register for that digit. The new register is used from the next output update.
- `load` while `busy` = 1 is dropped, with no queuing.
- **Reset mid-conversion:** `rst_n` low for one edge aborts SHIFT and returns all reset values. The previous display register is not preserved.
- `rst_n` low together with `load`: reset wins.
- **Blink:** `blink_tick` & `blink_en` at edge K gives a toggled phase at K+1, which reaches `an` at K+2. `blink_en` falling clears the phase on the next edge.
- No output is combinational from an input.

## Structure
- Shared package `seg_pkg` holds:
  - the 7-bit active-low segment patterns for 0–9 and `SEG_OFF` = 7'h7F;
  - `AN_OFF` = 4'hF;
  - the state encoding IDLE/SHIFT/DONE;
  - `BIN_W` = 14 and `MAX_VAL` = 9999.
- One sub-module, `bin2bcd_seq`. It contains the converter FSM, scratch registers and shift counter, with a start/busy/done interface. `seg_scan` instantiates it and owns the scan, blanking and blink logic.

## Test plan
- **Reset, then one scan edge:** reset, then one `scan_clk` rising edge. Expect `busy` = 0, and `an` = 4'b1111 until the first scan edge. After that edge the index is 1, digit 1 is blanked, and `an` = 1111, `seg` = 7F. After the scan wraps to index 0: `an` = 1110, `seg` = 7'b1000000 ("0").
- **Load 1234:** load `value` = 1234 at cycle N. Expect `busy` high for exactly 15 cycles. Over four scan edges, expect digits 4, 3, 2, 1 on `an` = 1110, 1101, 1011, 0111, with `seg` = 7'h19, 7'h30, 7'h24, 7'h79.
- **Saturation and blanking:** load 16383, and expect the display to read 9999. Then load 7, and expect only `an` = 1110 ever to go active, with `seg` = 7'h78.
- **Load while busy:** load 42, and pulse `load` with 999 at N+5. Expect the display to read 42 and `busy` to fall at N+16.
- **Blink:** with `blink_en` = 1, give one `blink_tick`. Expect `an` = 1111 from two cycles later. A second tick restores scanning. Dropping `blink_en` while the phase = 1 restores scanning within 2 cycles.
- **Reset mid-conversion:** assert `rst_n` = 0 at N+7 of a load of 5678. Expect `busy` = 0 next cycle and the display register = 0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants, state encoding and segment decode for the seg_scan display driver.
package seg_pkg;

    localparam int unsigned DIGITS  = 4;
    localparam int unsigned BIN_W   = 14;
    localparam int unsigned BCD_W   = 16;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned MAX_VAL = 9999;

    localparam logic [SEG_W-1:0]  SEG_OFF = 7'h7F;
    localparam logic [DIGITS-1:0] AN_OFF  = 4'hF;

    // Active-low {g,f,e,d,c,b,a}; entry 9 first so SEG_PAT[d] yields digit d.
    localparam logic [9:0][SEG_W-1:0] SEG_PAT = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_e;

    function automatic logic [SEG_W-1:0] seg_pattern(input logic [3:0] d);
        if (d > 4'd9) begin
            return SEG_OFF;
        end
        return SEG_PAT[d];
    endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Control/display bundle between the display driver and its upstream/downstream logic.
interface seg_scan_if;
    import seg_pkg::*;

    logic                scan_clk;
    logic                blink_tick;
    logic                blink_en;
    logic [BIN_W-1:0]    value;
    logic                load;
    logic                busy;
    logic [DIGITS-1:0]   an;
    logic [SEG_W-1:0]    seg;

    modport master (
        output scan_clk, blink_tick, blink_en, value, load,
        input  busy, an, seg
    );

    modport slave (
        input  scan_clk, blink_tick, blink_en, value, load,
        output busy, an, seg
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: saturates the input, then 14 shift/add-3 steps into a 16-bit BCD scratch.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [BCD_W-1:0] bcd_o
);

    conv_state_e      state_q;
    logic [BIN_W-1:0] bin_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] adj_c;
    logic [3:0]       cnt_q;
    logic             busy_q;
    logic             done_q;

    // Add 3 to every nibble that would overflow past 9 after the shift.
    always_comb begin
        adj_c = bcd_q;
        for (int n = 0; n < 4; n++) begin
            if (bcd_q[4*n +: 4] >= 4'd5) begin
                adj_c[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        bin_q   <= (bin_i > BIN_W'(MAX_VAL)) ? BIN_W'(MAX_VAL) : bin_i;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bcd_q <= {adj_c[BCD_W-2:0], bin_q[BIN_W-1]};
                    bin_q <= {bin_q[BIN_W-2:0], 1'b0};
                    if (cnt_q == 4'(BIN_W - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment driver with leading-zero blanking and blink.
module seg_scan
    import seg_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    seg_scan_if.slave bus
);

    logic             conv_busy;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;

    bin2bcd_seq u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (bus.load),
        .bin_i   (bus.value),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    logic              scan_prev_q;
    logic [1:0]        idx_q;
    logic [BCD_W-1:0]  disp_q;
    logic              blink_q;
    logic              upd_q;
    logic [DIGITS-1:0] pat_an_q;
    logic [SEG_W-1:0]  pat_seg_q;
    logic [DIGITS-1:0] an_q;
    logic [SEG_W-1:0]  seg_q;

    logic              scan_edge_c;
    logic              blink_d;
    logic [1:0]        idx_nx_c;
    logic [3:0]        digit_c;
    logic [3:0]        blank_c;
    logic [DIGITS-1:0] pat_an_d;
    logic [SEG_W-1:0]  pat_seg_d;

    // The pattern for the upcoming digit is taken from the display register at the scan edge.
    always_comb begin
        scan_edge_c = bus.scan_clk & ~scan_prev_q;
        blink_d     = bus.blink_en & (blink_q ^ bus.blink_tick);
        idx_nx_c    = idx_q + 2'd1;
        blank_c[3]  = (disp_q[15:12] == 4'd0);
        blank_c[2]  = blank_c[3] & (disp_q[11:8] == 4'd0);
        blank_c[1]  = blank_c[2] & (disp_q[7:4] == 4'd0);
        blank_c[0]  = 1'b0;
        digit_c     = disp_q[{idx_nx_c, 2'b00} +: 4];
        pat_an_d    = ~(DIGITS'(1) << idx_nx_c);
        pat_seg_d   = seg_pattern(digit_c);
        if (blank_c[idx_nx_c]) begin
            pat_an_d  = AN_OFF;
            pat_seg_d = SEG_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_prev_q <= 1'b1;
            idx_q       <= '0;
            disp_q      <= '0;
            blink_q     <= 1'b0;
            upd_q       <= 1'b0;
            pat_an_q    <= AN_OFF;
            pat_seg_q   <= SEG_OFF;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
        end else begin
            scan_prev_q <= bus.scan_clk;
            if (scan_edge_c) begin
                idx_q     <= idx_nx_c;
                pat_an_q  <= pat_an_d;
                pat_seg_q <= pat_seg_d;
            end
            if (conv_done) begin
                disp_q <= conv_bcd;
            end
            blink_q <= blink_d;
            upd_q   <= scan_edge_c | (blink_d ^ blink_q);
            if (upd_q) begin
                an_q  <= blink_q ? AN_OFF  : pat_an_q;
                seg_q <= blink_q ? SEG_OFF : pat_seg_q;
            end
        end
    end

    assign bus.busy = conv_busy;
    assign bus.an   = an_q;
    assign bus.seg  = seg_q;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: stimulus queues timed expectations, a negedge monitor checks them.
module tb_seg_scan;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg_scan_if bus ();

    seg_scan dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         cyc;
        bit         chk_disp;
        logic [3:0] an;
        logic [6:0] seg;
        bit         chk_busy;
        logic       busy;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    bit   stim_done = 1'b0;

    int   idx_m = 0;
    int   val_m = 0;
    bit   blink_m = 1'b0;

    logic [6:0] seg_tb [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [10:0] OFF = {4'hF, 7'h7F};

    function automatic logic [10:0] exp_out(int val, int idx, bit off);
        int p;
        int d;
        p = (idx == 0) ? 1 : (idx == 1) ? 10 : (idx == 2) ? 100 : 1000;
        d = (val / p) % 10;
        if (off || (idx > 0 && val < p)) return OFF;
        return {~(4'b0001 << idx), seg_tb[d]};
    endfunction

    task automatic push_disp(int dc, logic [10:0] o, string nm);
        exp_t e;
        e.cyc = cyc + dc; e.chk_disp = 1'b1; e.an = o[10:7]; e.seg = o[6:0];
        e.chk_busy = 1'b0; e.busy = 1'b0; e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic push_busy(int dc, logic b, string nm);
        exp_t e;
        e.cyc = cyc + dc; e.chk_disp = 1'b0; e.an = 4'h0; e.seg = 7'h0;
        e.chk_busy = 1'b1; e.busy = b; e.name = nm;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            if (mon_e.cyc < cyc) begin
                n_vec++; n_err++;
                $display("FAIL %s: check due at cycle %0d not taken until %0d", mon_e.name, mon_e.cyc, cyc);
            end else begin
                if (mon_e.chk_disp) begin
                    n_vec++;
                    if (bus.an !== mon_e.an || bus.seg !== mon_e.seg) begin
                        n_err++;
                        $display("FAIL %s @%0d: got an=%b seg=%h, expected an=%b seg=%h",
                                 mon_e.name, cyc, bus.an, bus.seg, mon_e.an, mon_e.seg);
                    end
                end
                if (mon_e.chk_busy) begin
                    n_vec++;
                    if (bus.busy !== mon_e.busy) begin
                        n_err++;
                        $display("FAIL %s @%0d: got busy=%b, expected busy=%b",
                                 mon_e.name, cyc, bus.busy, mon_e.busy);
                    end
                end
            end
        end
        if (stim_done) begin
            if (sb_q.size() > 0) begin
                $display("FAIL drain: %0d expectations never checked", sb_q.size());
                n_vec += sb_q.size();
                n_err += sb_q.size();
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

    task automatic scan_step(string nm);
        idx_m = (idx_m + 1) % 4;
        bus.scan_clk = 1'b1;
        push_disp(2, exp_out(val_m, idx_m, blink_m), nm);
        @(negedge clk);
        bus.scan_clk = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic scan_all(string nm);
        repeat (4) scan_step(nm);
    endtask

    // Load v; optional second load pulse (999) at offset extra_at, optional scan edge at offset scan_at.
    task automatic do_load(int v, int extra_at, int scan_at);
        int old_v;
        old_v = val_m;
        push_busy(1, 1'b1, "busy_rise");
        push_busy(15, 1'b1, "busy_hold");
        push_busy(16, 1'b0, "busy_fall");
        for (int k = 0; k < 17; k++) begin
            bus.load  = (k == 0) || (k == extra_at);
            bus.value = (k == extra_at) ? 14'd999 : 14'(v);
            if (k == scan_at) begin
                idx_m = (idx_m + 1) % 4;
                bus.scan_clk = 1'b1;
                push_disp(2, exp_out(old_v, idx_m, blink_m), "scan_at_done");
            end else begin
                bus.scan_clk = 1'b0;
            end
            @(negedge clk);
        end
        bus.load = 1'b0;
        val_m = (v > 9999) ? 9999 : v;
    endtask

    task automatic blink_tick_once(string nm);
        push_disp(1, exp_out(val_m, idx_m, blink_m), {nm, "_lat"});
        blink_m = ~blink_m;
        bus.blink_tick = 1'b1;
        push_disp(2, exp_out(val_m, idx_m, blink_m), nm);
        @(negedge clk);
        bus.blink_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.scan_clk = 1'b1; bus.blink_tick = 1'b0; bus.blink_en = 1'b0;
        bus.load = 1'b0; bus.value = '0;

        @(negedge clk);
        push_disp(1, OFF, "reset_out");
        push_busy(1, 1'b0, "reset_busy");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.scan_clk = 1'b0;
        push_disp(1, OFF, "pre_scan_off");
        @(negedge clk);
        @(negedge clk);
        scan_all("reset_scan");

        do_load(1234, -1, -1);
        scan_all("disp_1234");

        bus.blink_en = 1'b1;
        @(negedge clk);
        blink_tick_once("blink_on");
        scan_step("blink_scan_off");
        blink_tick_once("blink_off");
        blink_tick_once("blink_on2");
        push_disp(1, OFF, "blink_drop_lat");
        bus.blink_en = 1'b0;
        blink_m = 1'b0;
        push_disp(2, exp_out(val_m, idx_m, 1'b0), "blink_drop");
        repeat (3) @(negedge clk);

        do_load(16383, -1, -1);
        scan_all("sat_9999");
        do_load(7, -1, 15);
        scan_all("blank_7");
        do_load(42, 5, -1);
        scan_all("busy_drop_42");

        // Reset in the middle of a conversion of 5678.
        push_busy(1, 1'b1, "mid_busy_rise");
        push_busy(7, 1'b1, "mid_busy_hold");
        push_busy(8, 1'b0, "busy_after_rst");
        push_disp(8, OFF, "out_after_rst");
        for (int k = 0; k < 9; k++) begin
            bus.load  = (k == 0);
            bus.value = 14'd5678;
            rst_n     = (k != 7);
            @(negedge clk);
        end
        val_m = 0; idx_m = 0; blink_m = 1'b0;
        repeat (2) @(negedge clk);
        scan_all("rst_disp");

        repeat (3) @(negedge clk);
        stim_done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
